// File: rtl/sram_ctrl.sv
`timescale 1ns/1ps
// sram_ctrl: synchronous initiator for an asynchronous cs/we/oe SRAM with a
// shared bidirectional data bus. One host request at a time is accepted over
// a valid/ready handshake and played out as a timed pin sequence; completion
// is reported with a one-cycle rsp_valid strobe carrying any read data.
module sram_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 4,
  parameter int WR_PULSE = 2,  // cycles sram_we is high per write (1..15)
  parameter int RD_WAIT  = 2   // cycles sram_oe is high before capture (1..15)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_cs,
  output logic              sram_we,
  output logic              sram_oe
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_RD_ACCESS
  } state_t;

  // The phase counter runs from LOAD down to zero, so a phase of N cycles
  // loads N-1.
  localparam logic [3:0] WR_LOAD = 4'(WR_PULSE - 1);
  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              capture;
  logic              done;
  logic              drive_bus;

  // State and phase-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter reload and per-cycle strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_we) begin
            state_d = ST_WR_SETUP;
          end else begin
            state_d = ST_RD_ACCESS;
            cnt_d   = RD_LOAD;
          end
        end
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        cnt_d   = WR_LOAD;
      end
      ST_WR_PULSE: begin
        if (cnt_q == '0) state_d = ST_WR_HOLD;
        else             cnt_d   = cnt_q - 4'd1;
      end
      ST_WR_HOLD: begin
        state_d = ST_IDLE;
        done    = 1'b1;
      end
      ST_RD_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          capture = 1'b1;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture and response registers; the address flop also drives the
  // SRAM address pins and holds its value while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done;
      if (accept) begin
        sram_addr <= req_addr;
        wdata_q   <= req_wdata;
      end
      if (capture) rsp_rdata <= sram_data;
    end
  end

  // Pin controls decode from the state register only, so host inputs can
  // never reach the SRAM strobes combinationally.
  assign req_ready = (state_q == ST_IDLE);
  assign sram_cs   = (state_q != ST_IDLE);
  assign sram_we   = (state_q == ST_WR_PULSE);
  assign sram_oe   = (state_q == ST_RD_ACCESS);
  assign drive_bus = (state_q == ST_WR_SETUP) || (state_q == ST_WR_PULSE) ||
                     (state_q == ST_WR_HOLD);

  // The bus is driven only during write states, which never overlap oe.
  assign sram_data = drive_bus ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_ctrl.sv
`timescale 1ns/1ps
// tb_sram_ctrl: randomized and directed stimulus against a transaction-level
// reference model. The driver pushes expected responses and pin windows into
// queues; independent negedge monitors pop and compare.
module tb_sram_ctrl;
  localparam int WRP    = 2;
  localparam int RDW    = 2;
  localparam int WR_LEN = WRP + 2;  // busy cycles of a write
  localparam int RD_LEN = RDW;      // busy cycles of a read

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [3:0] data;
    logic [3:0] rdata;
    int         n;  // accept edge number
  } txn_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_we, req_ready, rsp_valid;
  logic [7:0] req_addr, sram_addr;
  logic [3:0] req_wdata, rsp_rdata;
  wire  [3:0] sram_data;
  logic       sram_cs, sram_we, sram_oe;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  txn_t pin_q[$];
  txn_t rsp_q[$];
  logic [3:0] ref_mem [256];
  logic [3:0] sram_mem [256];
  logic [3:0] last_rdata;
  logic [7:0] last_addr;
  logic       load_mem;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_ctrl #(.ADDR_W(8), .DATA_W(4), .WR_PULSE(WRP), .RD_WAIT(RDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_oe(sram_oe)
  );

  function automatic logic [3:0] init_val(input int i);
    return 4'((i * 7 + 3) & 15);
  endfunction

  // SRAM device model: drives the bus on reads, stores while we is high.
  assign sram_data = (sram_cs && sram_oe && !sram_we) ? sram_mem[sram_addr] : 4'bz;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= init_val(i);
    end else if (sram_cs && sram_we) begin
      sram_mem[sram_addr] <= sram_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Pin monitor: each accepted request owns a window of busy cycles.
  always @(negedge clk) begin : pin_mon
    txn_t t;
    int   k, len;
    if (!rst) begin
      if (pin_q.size() > 0 && pin_q[0].n <= cyc) begin
        t   = pin_q[0];
        k   = cyc - t.n;
        len = t.we ? WR_LEN : RD_LEN;
        if (k < len) begin
          check("busy_cs", sram_cs, 1);
          check("busy_ready", req_ready, 0);
          check("busy_addr", sram_addr, t.addr);
          if (t.we) begin
            check("wr_we", sram_we, (k >= 1 && k <= WRP) ? 1 : 0);
            check("wr_oe", sram_oe, 0);
            check("wr_bus", sram_data, t.data);
          end else begin
            check("rd_oe", sram_oe, 1);
            check("rd_we", sram_we, 0);
            check("rd_bus", sram_data, sram_mem[t.addr]);
          end
          last_addr = t.addr;
        end else begin
          pin_q.pop_front();
        end
      end
      if (pin_q.size() == 0 || pin_q[0].n > cyc) begin
        check("idle_cs", sram_cs, 0);
        check("idle_we", sram_we, 0);
        check("idle_oe", sram_oe, 0);
        check("idle_ready", req_ready, 1);
        check("idle_addr", sram_addr, last_addr);
      end
    end
  end

  // Response monitor: in-order scoreboard with exact completion cycle.
  always @(negedge clk) begin : rsp_mon
    txn_t t;
    if (!rst && rsp_valid) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", rsp_valid, 0);
      end else begin
        t = rsp_q.pop_front();
        check("rsp_cycle", cyc, t.n + (t.we ? WR_LEN : RD_LEN));
        check("rsp_rdata", rsp_rdata, t.rdata);
      end
    end
  end

  // Issue one request; junk with req_valid high is shown while busy.
  task automatic do_req(input logic we, input logic [7:0] a, input logic [3:0] d,
                        output int n);
    txn_t t;
    int   guard = 0;
    n = -1;
    while (!req_ready && guard < 50) begin
      req_valid = 1'b1;
      req_we    = 1'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = 4'($urandom);
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("ready_timeout", req_ready, 1);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    t.we   = we;
    t.addr = a;
    t.data = d;
    t.n    = cyc + 1;
    if (we) begin
      ref_mem[a] = d;
      t.rdata    = last_rdata;
    end else begin
      t.rdata    = ref_mem[a];
      last_rdata = ref_mem[a];
    end
    n = t.n;
    pin_q.push_back(t);
    rsp_q.push_back(t);
    @(negedge clk);
    req_we    = 1'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = 4'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    req_valid = 1'b0;
    while ((pin_q.size() != 0 || rsp_q.size() != 0) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", pin_q.size() + rsp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, n2, n3;
    logic       we;
    logic [7:0] a;
    rst = 1'b1; load_mem = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    last_rdata = '0; last_addr = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    repeat (3) @(negedge clk);
    check("rst_cs", sram_cs, 0);
    check("rst_we", sram_we, 0);
    check("rst_oe", sram_oe, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_addr", sram_addr, 0);
    load_mem = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", req_ready, 1);

    // Single write then read back.
    do_req(1'b1, 8'h3C, 4'hA, n0); drain();
    check("mem_3c", sram_mem[8'h3C], 4'hA);
    do_req(1'b0, 8'h3C, 4'h0, n0); drain();

    // Streaming with req_valid held high.
    do_req(1'b1, 8'h00, 4'h5, n0);
    do_req(1'b1, 8'hFF, 4'hF, n1);
    do_req(1'b0, 8'hFF, 4'h0, n2);
    do_req(1'b0, 8'h00, 4'h0, n3);
    drain();
    check("stream_gap_ww", n1 - n0, WR_LEN + 1);
    check("stream_gap_wr", n2 - n1, WR_LEN + 1);
    check("stream_gap_rr", n3 - n2, RD_LEN + 1);

    // Reset in the middle of a write pulse.
    do_req(1'b1, 8'h10, 4'h7, n0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    pin_q.delete();
    rsp_q.delete();
    req_valid  = 1'b0;
    last_rdata = '0;
    last_addr  = '0;
    #1;
    check("midrst_we", sram_we, 0);
    check("midrst_cs", sram_cs, 0);
    check("midrst_oe", sram_oe, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_rdata", rsp_rdata, 0);
    check("midrst_addr", sram_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", req_ready, 1);
    do_req(1'b1, 8'h10, 4'h3, n0); drain();
    do_req(1'b0, 8'h10, 4'h0, n0); drain();

    // Randomized mix, concentrated on a few addresses for read-after-write.
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      do_req(we, a, 4'($urandom), n0);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Synchronous initiator for the team's asynchronous 8-bit-address / 4-bit-data SRAM (cs/we/oe, shared bidirectional data bus). Accepts single read or write requests from a clocked host through a valid/ready handshake and sequences the SRAM pins with setup, pulse and hold timing. Returns read data through a one-cycle response strobe. Sits between system logic and the SRAM model or device.

Parameters:
ADDR_W, 8, SRAM address width
DATA_W, 4, SRAM data width
WR_PULSE, 2, cycles sram_we is held high per write; legal range 1..15
RD_WAIT, 2, cycles sram_oe is held high before read data is captured; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  host request present
req_ready  output  1  controller can accept a request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  request address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle pulse: request completed
rsp_rdata  output  DATA_W  captured read data
sram_addr  output  ADDR_W  SRAM address
sram_data  inout  DATA_W  SRAM data bus
sram_cs  output  1  SRAM chip select, active high
sram_we  output  1  SRAM write enable, active high
sram_oe  output  1  SRAM output enable, active high

Behaviour:
- Reset (async, immediate): state IDLE; sram_cs/we/oe=0; sram_data=Z; sram_addr=0; rsp_valid=0; rsp_rdata=0; counter=0; req_ready=1 once rst deasserts.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS.
- req_ready = (state==IDLE). Accept when req_valid && req_ready on a rising edge. On accept, register addr, we and wdata. Request inputs are ignored in every other cycle.
- sram_* outputs come from flops or are decoded from state only. There is no combinational path from req_* to sram_*, so sram_we cannot glitch.
- Write sequence (accept at edge n):
  - WR_SETUP, 1 cycle: cs=1, we=0, oe=0, addr and data driven.
  - WR_PULSE, WR_PULSE cycles: cs=1, we=1.
  - WR_HOLD, 1 cycle: cs=1, we=0, data still driven.
  - Return to IDLE at edge n+WR_PULSE+2, with rsp_valid=1 for that one cycle. rsp_rdata is unchanged.
- Read sequence (accept at edge n):
  - RD_ACCESS, RD_WAIT cycles: cs=1, oe=1, we=0, sram_data released (Z), addr held.
  - sram_data is captured into rsp_rdata at edge n+RD_WAIT. The block returns to IDLE on that edge, with rsp_valid=1 for one cycle.
- Bus ownership: the controller drives sram_data only in WR_SETUP, WR_PULSE and WR_HOLD. It never drives while sram_oe=1, so there is no contention.
- sram_addr holds its last value in IDLE. cs=0 in IDLE.
- Back-to-back: a new request may be accepted in the same cycle rsp_valid is high, so there are no idle bubbles beyond that cycle.
- Address wrap is not applicable: each request is independent. Address 0xFF is legal.
- Reset mid-operation: pins return to the reset state immediately. The in-flight request is dropped and no rsp_valid is issued for it.
- Counter counts phase cycles within WR_PULSE and RD_ACCESS. It reloads on state entry and is 4 bits wide.

Test Plan:
- Reset: assert rst mid-cycle -> sram_cs/we/oe drop without waiting for clk; sram_data=Z; rsp_valid=0; rsp_rdata=0; req_ready=1 after release.
- Write 0x3C<-0xA (WR_PULSE=2) -> cs high 4 cycles; we high exactly cycles 2-3; addr=0x3C and data=0xA for all 4 cycles; rsp_valid on the 5th cycle after accept; SRAM model mem[0x3C]=0xA.
- Read 0x3C (RD_WAIT=2) -> cs and oe high 2 cycles; controller not driving sram_data; rsp_valid with rsp_rdata=0xA at edge n+2; rsp_valid high for exactly one cycle.
- Streaming with req_valid held high: W 0x00<-0x5, W 0xFF<-0xF, R 0xFF, R 0x00 -> each accepted in the prior rsp_valid cycle; reads return 0xF then 0x5; bench checker flags any cycle where oe=1 while the controller drives the bus.
- Busy stall: req_valid high with changing req_addr during WR_PULSE -> ignored; only the value present when req_ready=1 is used.
- Reset during WR_PULSE of write 0x10<-0x7 -> we=0 immediately, no rsp_valid; then write 0x10<-0x3 and read 0x10 -> rsp_rdata=0x3.
